// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SIZE    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_CSUM    = 2'd3
  } err_code_t;

endpackage

// File: rtl/imem_word_packer.sv
// Collects data bytes into lanes and issues one registered memory write per word.
module imem_word_packer
  import imem_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [1:0]       byte_idx,
  input  logic [7:0]       byte_in,
  input  logic [CNT_W-1:0] word_idx,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata
);

  logic [7:0]  lane0_q, lane1_q, lane2_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        last_byte;

  // The top lane is never stored: it completes the word directly from the input.
  assign last_byte = load && (byte_idx == 2'(WORD_BYTES - 1));

  // Steer each accepted byte into its lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane0_q <= '0;
      lane1_q <= '0;
      lane2_q <= '0;
    end else if (load) begin
      case (byte_idx)
        2'd0:    lane0_q <= byte_in;
        2'd1:    lane1_q <= byte_in;
        2'd2:    lane2_q <= byte_in;
        default: ;
      endcase
    end
  end

  // Write strobe pulses one cycle after the last byte; address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= last_byte;
      if (last_byte) begin
        addr_q  <= 32'(word_idx) * 32'(WORD_BYTES);
        wdata_q <= {byte_in, lane2_q, lane1_q, lane0_q};
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted, XOR-checked byte stream into instruction memory
// and holds the CPU in reset until a verified image is present.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic             cpu_rst_n,
  output logic [CNT_W-1:0] words_loaded
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] hdr_count;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  err_code_t        err_q, err_d;
  logic             in_busy, accept, data_accept;

  assign in_busy     = state_q inside {HDR0, HDR1, DATA, CHK};
  assign accept      = in_busy && s_valid;
  assign data_accept = accept && (state_q == DATA);
  assign hdr_count   = CNT_W'({s_data, count_q[7:0]});

  // Next-state, header/data bookkeeping and inactivity watchdog.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    words_d    = words_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    idle_d     = idle_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = HDR0;
          words_d    = '0;
          byte_idx_d = '0;
          csum_d     = '0;
          idle_d     = '0;
          err_d      = ERR_NONE;
        end
      end
      HDR0: begin
        if (accept) begin
          count_d[7:0] = s_data;
          state_d      = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          count_d = hdr_count;
          if (hdr_count == '0 || hdr_count > CNT_W'(DEPTH)) begin
            state_d = ERR;
            err_d   = ERR_SIZE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ s_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'(WORD_BYTES - 1)) begin
            words_d = words_q + CNT_W'(1);
            if (words_q + CNT_W'(1) == count_q) state_d = CHK;
          end
        end
      end
      CHK: begin
        if (accept) begin
          if (s_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept in the expiry cycle still counts as activity.
    if (in_busy) begin
      if (accept) begin
        idle_d = '0;
      end else if (idle_q == IDLE_W'(TIMEOUT_CYC)) begin
        state_d = ERR;
        err_d   = ERR_TIMEOUT;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      words_q    <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      idle_q     <= '0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      words_q    <= words_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
    end
  end

  imem_word_packer #(
    .CNT_W(CNT_W)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (data_accept),
    .byte_idx (byte_idx_q),
    .byte_in  (s_data),
    .word_idx (words_q),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata)
  );

  assign s_ready      = in_busy;
  assign busy         = in_busy;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign err_code     = err_q;
  assign cpu_rst_n    = (state_q == DONE);
  assign words_loaded = words_q;

endmodule
